// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared state encoding and width helpers for the sequence timer
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int min1_clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int presc_w(input int prescale);
    return min1_clog2(prescale);
  endfunction

endpackage

// File: rtl/serial_pattern_match.sv
// rtl/serial_pattern_match.sv - serial history buffer and start-pattern compare
module serial_pattern_match
  import fsm_seq_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic data,
  output logic match
);

  localparam int                CNT_W    = min1_clog2(PATTERN_W);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(PATTERN_W - 1);

  logic [PATTERN_W-2:0] hist_q;
  logic [CNT_W-1:0]     hist_cnt_q;
  logic [PATTERN_W-1:0] window;

  assign window = {hist_q, data};

  // hist_cnt gating keeps a freshly cleared history from matching zero-led patterns
  assign match = en && (hist_cnt_q == CNT_FULL) && (window == PATTERN);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hist_q     <= '0;
      hist_cnt_q <= '0;
    end else if (en) begin
      hist_q <= window[PATTERN_W-2:0];
      if (hist_cnt_q != CNT_FULL) begin
        hist_cnt_q <= hist_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fsm_seq_timer_gen.sv
// rtl/fsm_seq_timer_gen.sv - pattern-triggered serial-delay prescaled timer with done/ack handshake
module fsm_seq_timer_gen
  import fsm_seq_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter int                   SHIFT_W   = 4,
  parameter int                   PRESCALE  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
  input  logic               abort,
  output logic               shift_ena,
  output logic               counting,
  output logic               done,
  output logic [SHIFT_W-1:0] count
);

  localparam int             PW        = presc_w(PRESCALE);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);
  localparam int             BW        = min1_clog2(SHIFT_W);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(SHIFT_W - 1);

  state_t             state_q, state_d;
  logic               match;
  logic               hist_clr;
  logic [BW-1:0]      bit_cnt_q;
  logic [SHIFT_W-1:0] delay_q;
  logic [SHIFT_W:0]   delay_ext;
  logic [SHIFT_W-1:0] delay_nx;
  logic [SHIFT_W-1:0] cnt_q;
  logic [PW-1:0]      presc_q;
  logic               last_bit;
  logic               presc_zero;
  logic               cnt_zero;

  serial_pattern_match #(
    .PATTERN_W(PATTERN_W),
    .PATTERN  (PATTERN)
  ) u_match (
    .clk  (clk),
    .reset(reset),
    .clr  (hist_clr),
    .en   (state_q == SEARCH),
    .data (data),
    .match(match)
  );

  // widening first keeps SHIFT_W==1 legal without a negative slice
  assign delay_ext  = {delay_q, data};
  assign delay_nx   = delay_ext[SHIFT_W-1:0];
  assign last_bit   = (bit_cnt_q == BIT_LAST);
  assign presc_zero = (presc_q == '0);
  assign cnt_zero   = (cnt_q == '0);

  assign shift_ena = (state_q == SHIFT);
  assign counting  = (state_q == COUNT);
  assign done      = (state_q == DONE);
  assign count     = counting ? cnt_q : '0;

  always_comb begin
    state_d  = state_q;
    hist_clr = 1'b0;
    case (state_q)
      SEARCH: begin
        if (match) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_d  = SEARCH;
          hist_clr = 1'b1;
        end else if (last_bit) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          state_d  = SEARCH;
          hist_clr = 1'b1;
        end else if (presc_zero && cnt_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          state_d  = SEARCH;
          hist_clr = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      delay_q   <= '0;
      cnt_q     <= '0;
      presc_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        SEARCH: bit_cnt_q <= '0;
        SHIFT: begin
          delay_q   <= delay_nx;
          bit_cnt_q <= bit_cnt_q + BW'(1);
          if (last_bit) begin
            cnt_q   <= delay_nx;
            presc_q <= PRESC_MAX;
          end
        end
        COUNT: begin
          // each unit lasts PRESCALE cycles; the final unit ends with cnt at zero
          if (presc_zero) begin
            if (!cnt_zero) begin
              cnt_q   <= cnt_q - SHIFT_W'(1);
              presc_q <= PRESC_MAX;
            end
          end else begin
            presc_q <= presc_q - PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_seq_timer_gen.sv
// tb/tb_fsm_seq_timer_gen.sv - self-checking bench for fsm_seq_timer_gen
module tb_fsm_seq_timer_gen;

  logic       clk = 1'b0;
  logic       reset, data, ack, abort;
  logic       shift_ena, counting, done;
  logic [3:0] count;
  logic       data_b;
  logic       b_shift_ena, b_counting, b_done;
  logic [3:0] b_count;

  int checks = 0;
  int errors = 0;
  int hq[$];
  bit noise = 1'b0;

  always #5 clk = ~clk;

  fsm_seq_timer_gen #(.PATTERN_W(4), .PATTERN(4'b1101), .SHIFT_W(4), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .abort(abort),
    .shift_ena(shift_ena), .counting(counting), .done(done), .count(count)
  );

  fsm_seq_timer_gen #(.PATTERN_W(4), .PATTERN(4'b0001), .SHIFT_W(4), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .data(data_b), .ack(1'b0), .abort(1'b0),
    .shift_ena(b_shift_ena), .counting(b_counting), .done(b_done), .count(b_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input bit se, input bit cn, input bit dn, input logic [3:0] cv);
    chk({tag, ".shift_ena"}, 32'(shift_ena), 32'(se));
    chk({tag, ".counting"}, 32'(counting), 32'(cn));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".count"}, 32'(count), 32'(cv));
  endtask

  task automatic do_reset;
    reset = 1'b1; data = 1'b0; ack = 1'b0; abort = 1'b0; data_b = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    hq.delete();
    expect_outs("reset", 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // Reference: match when the last four bits received since the last clear equal 1101
  task automatic feed_bit(input bit b, output bit m);
    data = b;
    if (noise) begin
      ack   = 1'($urandom % 2);
      abort = 1'($urandom % 2);
    end
    hq.push_back(int'(b));
    if (hq.size() > 4) void'(hq.pop_front());
    m = (hq.size() == 4) && (hq[0] == 1) && (hq[1] == 1) && (hq[2] == 0) && (hq[3] == 1);
    tick;
    chk("search.shift_ena", 32'(shift_ena), 32'(m));
    if (m) hq.delete();
  endtask

  task automatic feed_pattern;
    bit m;
    logic [3:0] p;
    p = 4'b1101;
    for (int i = 3; i >= 0; i--) feed_bit(p[i], m);
  endtask

  // Entered in the first SHIFT cycle; leaves the DUT in its first DONE cycle
  task automatic run_delay(input string tag, input logic [3:0] d);
    int units;
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".shift"}, 32'({shift_ena, counting}), 32'(2'b10));
      data = d[3-i];
      if (noise) ack = 1'($urandom % 2);
      tick;
    end
    units = int'(d) + 1;
    for (int k = 0; k < units * 4; k++) begin
      expect_outs({tag, ".count"}, 1'b0, 1'b1, 1'b0, 4'(int'(d) - k / 4));
      data = 1'($urandom % 2);
      if (noise) ack = 1'($urandom % 2);
      tick;
    end
    if (noise) ack = 1'b0;
    expect_outs({tag, ".done"}, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  task automatic finish_done(input string tag);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    hq.delete();
    expect_outs({tag, ".ack"}, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    bit m;
    logic [3:0] d;
    logic [6:0] s3;
    logic [4:0] s2;

    // 1: basic run, delay 2, done held three cycles
    do_reset;
    feed_pattern;
    run_delay("s1", 4'd2);
    tick;
    chk("s1.done_hold2", 32'(done), 32'd1);
    tick;
    chk("s1.done_hold3", 32'(done), 32'd1);
    finish_done("s1");
    tick;
    expect_outs("s1.idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // 2: overlapping prefix 1,1,1,0,1
    s2 = 5'b11101;
    for (int i = 4; i >= 0; i--) feed_bit(s2[i], m);
    chk("s2.match_on_5th", 32'(m), 32'd1);
    run_delay("s2", 4'd0);
    finish_done("s2");

    // 3: abort on the sixth COUNT cycle, then stale-history check
    feed_pattern;
    d = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      data = d[3-i];
      tick;
    end
    for (int k = 0; k < 5; k++) begin
      expect_outs("s3.pre_abort", 1'b0, 1'b1, 1'b0, 4'(2 - k / 4));
      tick;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    hq.delete();
    expect_outs("s3.abort", 1'b0, 1'b0, 1'b0, 4'd0);
    s3 = 7'b1011101;
    for (int i = 6; i >= 0; i--) feed_bit(s3[i], m);
    chk("s3.restart", 32'(m), 32'd1);
    run_delay("s3", 4'd1);
    finish_done("s3");

    // 4a: reset mid-SHIFT with data/ack active during reset
    feed_pattern;
    data = 1'b0; tick;
    data = 1'b1; tick;
    reset = 1'b1; ack = 1'b1; data = 1'b1;
    tick;
    expect_outs("s4.rst_shift", 1'b0, 1'b0, 1'b0, 4'd0);
    tick;
    tick;
    reset = 1'b0; ack = 1'b0;
    hq.delete();
    feed_bit(1'b0, m);
    feed_bit(1'b1, m);
    feed_pattern;
    d = 4'($urandom_range(0, 3));
    run_delay("s4", d);
    // 4b: reset mid-DONE
    reset = 1'b1; ack = 1'b1;
    tick;
    expect_outs("s4.rst_done", 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0; ack = 1'b0;
    hq.delete();
    tick;
    expect_outs("s4.after_rst", 1'b0, 1'b0, 1'b0, 4'd0);

    // 5: ack held through a delay-0 run
    ack = 1'b1;
    feed_pattern;
    run_delay("s5", 4'd0);
    tick;
    expect_outs("s5.one_cycle_done", 1'b0, 1'b0, 1'b0, 4'd0);
    hq.delete();
    ack = 1'b0;

    // randomized runs with random prefixes and ack/abort noise in SEARCH
    for (int r = 0; r < 6; r++) begin
      noise = 1'b1;
      m = 1'b0;
      for (int i = 0; i < 12 && !m; i++) feed_bit(1'($urandom % 2), m);
      if (!m) begin
        logic [3:0] p;
        p = 4'b1101;
        for (int i = 3; i >= 0 && !m; i--) feed_bit(p[i], m);
      end
      chk("rnd.matched", 32'(m), 32'd1);
      d = 4'($urandom_range(0, 15));
      run_delay("rnd", d);
      noise = 1'b0;
      abort = 1'b0;
      finish_done("rnd");
    end

    // 6: zero-led pattern 0001 must not match on cleared history
    do_reset;
    data_b = 1'b1; tick;
    chk("s6.no_false_match", 32'(b_shift_ena), 32'd0);
    data_b = 1'b0; tick;
    chk("s6.bit2", 32'(b_shift_ena), 32'd0);
    tick;
    chk("s6.bit3", 32'(b_shift_ena), 32'd0);
    tick;
    chk("s6.bit4", 32'(b_shift_ena), 32'd0);
    data_b = 1'b1; tick;
    chk("s6.match_0001", 32'(b_shift_ena), 32'd1);
    data_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
